// File: rtl/dcache_data_array.sv
// dcache_data_array
//   N-way L1 data-cache data store holding one line per (way, index).
//   Byte-strobed writes land at the accepting edge. Reads return every way
//   of the addressed set one cycle after acceptance, so the controller can
//   mux on the tag hit. A self-clearing init sequencer zeroes the whole
//   array after reset or when clear_i is pulsed while ready.
//
// Ports
//   clk_i        clock, all state on posedge
//   rst_i        synchronous active-high reset
//   clear_i      pulse: re-zero the entire array (ignored while initialising)
//   req_valid_i  request valid
//   req_ready_o  request accepted when valid & ready
//   req_write_i  1 = write, 0 = read
//   req_way_i    target way (writes only)
//   req_index_i  set index
//   req_wdata_i  write data
//   req_wstrb_i  per-byte write enable; bit b covers data[8b+7:8b]
//   rsp_valid_o  one-cycle pulse per accepted read
//   rsp_rdata_o  all ways of the read set; way w at [w*LINE_BITS +: LINE_BITS]
//   init_busy_o  high while the init sequencer runs
module dcache_data_array #(
  parameter int WAYS       = 2,
  parameter int INDEX_BITS = 5,
  parameter int LINE_BITS  = 256,
  parameter int WAY_BITS   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [WAY_BITS-1:0]       req_way_i,
  input  logic [INDEX_BITS-1:0]     req_index_i,
  input  logic [LINE_BITS-1:0]      req_wdata_i,
  input  logic [LINE_BITS/8-1:0]    req_wstrb_i,
  output logic                      rsp_valid_o,
  output logic [WAYS*LINE_BITS-1:0] rsp_rdata_o,
  output logic                      init_busy_o
);

  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam int STRB  = LINE_BITS / 8;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t                state, state_nxt;
  logic [INDEX_BITS-1:0] init_cnt, init_cnt_nxt;
  logic                  wr_acc, rd_acc;
  logic [LINE_BITS-1:0]  mem [WAYS][DEPTH];

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    req_ready_o  = 1'b0;
    init_busy_o  = 1'b0;
    case (state)
      S_INIT: begin
        init_busy_o  = 1'b1;
        init_cnt_nxt = init_cnt + 1'b1;
        // Last set is being zeroed this cycle; the sweep lasts DEPTH cycles.
        if (&init_cnt) state_nxt = S_READY;
      end
      default: begin
        // Clear takes priority: a request presented alongside it is refused.
        req_ready_o = !clear_i;
        if (clear_i) begin
          state_nxt    = S_INIT;
          init_cnt_nxt = '0;
        end
      end
    endcase
  end

  assign wr_acc = req_valid_i && req_ready_o && req_write_i;
  assign rd_acc = req_valid_i && req_ready_o && !req_write_i;

  // Control and response register (reset applies here only)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state       <= state_nxt;
      init_cnt    <= init_cnt_nxt;
      rsp_valid_o <= rd_acc;
      if (state == S_READY && clear_i) begin
        rsp_rdata_o <= '0;
      end else if (rd_acc) begin
        // No write can share the accepting edge, so the pre-edge contents
        // already equal what is stored after it.
        for (int w = 0; w < WAYS; w++) begin
          rsp_rdata_o[w*LINE_BITS +: LINE_BITS] <= mem[w][req_index_i];
        end
      end
    end
  end

  // Line storage: init sweep or byte-masked write
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == S_INIT) begin
        for (int w = 0; w < WAYS; w++) begin
          mem[w][init_cnt] <= '0;
        end
      end else if (wr_acc) begin
        // A way number with no matching way (>= WAYS) writes nothing.
        for (int w = 0; w < WAYS; w++) begin
          if (req_way_i == WAY_BITS'(w)) begin
            for (int b = 0; b < STRB; b++) begin
              if (req_wstrb_i[b]) begin
                mem[w][req_index_i][8*b +: 8] <= req_wdata_i[8*b +: 8];
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_data_array.sv
// tb_dcache_data_array
//   Directed bench for dcache_data_array with default parameters
//   (2 ways, 32 sets, 256-bit lines).
module tb_dcache_data_array;

  logic         clk = 1'b0;
  logic         rst_i, clear_i, req_valid_i, req_write_i;
  logic         req_ready_o, rsp_valid_o, init_busy_o;
  logic [0:0]   req_way_i;
  logic [4:0]   req_index_i;
  logic [255:0] req_wdata_i;
  logic [31:0]  req_wstrb_i;
  logic [511:0] rsp_rdata_o;

  int checks = 0;
  int errors = 0;
  int n;
  logic ready_seen;

  localparam logic [255:0] ZL = '0;

  dcache_data_array #(
    .WAYS(2), .INDEX_BITS(5), .LINE_BITS(256), .WAY_BITS(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_way_i(req_way_i),
    .req_index_i(req_index_i), .req_wdata_i(req_wdata_i),
    .req_wstrb_i(req_wstrb_i), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .init_busy_o(init_busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [0:0] way, input logic [4:0] idx,
                    input logic [255:0] data, input logic [31:0] strb);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_way_i = way;
    req_index_i = idx;  req_wdata_i = data;  req_wstrb_i = strb;
    step();
    req_valid_i = 1'b0; req_write_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] idx);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_index_i = idx;
    step();
    req_valid_i = 1'b0;
  endtask

  // Counts observations with init_busy_o high, starting just after the
  // edge that entered INIT; bounded so a stuck sequencer cannot hang.
  task automatic count_busy(output int cnt, output logic rdy_seen);
    cnt = 0;
    rdy_seen = 1'b0;
    while (init_busy_o && cnt < 100) begin
      if (req_ready_o) rdy_seen = 1'b1;
      cnt++;
      step();
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0;
    req_way_i = '0; req_index_i = '0; req_wdata_i = '0; req_wstrb_i = '0;

    // Reset state and init length
    step();
    rst_i = 1'b0;
    chk("rst_busy", 512'(init_busy_o), 512'd1);
    chk("rst_ready", 512'(req_ready_o), 512'd0);
    chk("rst_rsp_valid", 512'(rsp_valid_o), 512'd0);
    chk("rst_rdata", rsp_rdata_o, 512'd0);
    count_busy(n, ready_seen);
    chk("init_cycles", 512'(n), 512'd32);
    chk("init_ready_low", 512'(ready_seen), 512'd0);
    chk("ready_after_init", 512'(req_ready_o), 512'd1);

    // Full-line write to way1 set3, then read back
    wr(1'b1, 5'd3, {32{8'hA5}}, '1);
    chk("wr_no_rsp", 512'(rsp_valid_o), 512'd0);
    rd(5'd3);
    chk("rd3_valid", 512'(rsp_valid_o), 512'd1);
    chk("rd3_data", rsp_rdata_o, {{32{8'hA5}}, ZL});
    step();
    chk("rd3_pulse_end", 512'(rsp_valid_o), 512'd0);
    chk("rd3_hold", rsp_rdata_o, {{32{8'hA5}}, ZL});

    // wstrb=0 leaves the line alone
    wr(1'b1, 5'd3, '0, '0);
    rd(5'd3);
    chk("strb0_noop", rsp_rdata_o, {{32{8'hA5}}, ZL});

    // Single-byte merge over a 0x11-filled line
    wr(1'b0, 5'd7, {32{8'h11}}, '1);
    wr(1'b0, 5'd7, {{31{8'hFF}}, 8'h5C}, 32'h0000_0001);
    rd(5'd7);
    chk("merge_byte0", rsp_rdata_o, {ZL, {31{8'h11}}, 8'h5C});

    // Back-to-back reads with valid held
    wr(1'b0, 5'd0, {32{8'h10}}, '1);
    wr(1'b0, 5'd1, {32{8'h21}}, '1);
    wr(1'b1, 5'd1, {32{8'h2F}}, '1);
    wr(1'b0, 5'd2, {32{8'h32}}, '1);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_index_i = 5'd0;
    step();
    chk("b2b0_ready", 512'(req_ready_o), 512'd1);
    chk("b2b0_valid", 512'(rsp_valid_o), 512'd1);
    chk("b2b0_data", rsp_rdata_o, {ZL, {32{8'h10}}});
    req_index_i = 5'd1;
    step();
    chk("b2b1_valid", 512'(rsp_valid_o), 512'd1);
    chk("b2b1_data", rsp_rdata_o, {{32{8'h2F}}, {32{8'h21}}});
    req_index_i = 5'd2;
    step();
    chk("b2b2_ready", 512'(req_ready_o), 512'd1);
    chk("b2b2_valid", 512'(rsp_valid_o), 512'd1);
    chk("b2b2_data", rsp_rdata_o, {ZL, {32{8'h32}}});
    req_valid_i = 1'b0;
    step();
    chk("b2b_done", 512'(rsp_valid_o), 512'd0);

    // Write then immediate read of the same set
    wr(1'b1, 5'd4, {32{8'h4B}}, '1);
    rd(5'd4);
    chk("wr_then_rd", rsp_rdata_o, {{32{8'h4B}}, ZL});

    // Clear with a concurrent write: clear wins
    clear_i = 1'b1;
    req_valid_i = 1'b1; req_write_i = 1'b1; req_way_i = 1'b1;
    req_index_i = 5'd3; req_wdata_i = {32{8'h77}}; req_wstrb_i = '1;
    #1;
    chk("clear_ready_low", 512'(req_ready_o), 512'd0);
    step();
    clear_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0;
    chk("clear_busy", 512'(init_busy_o), 512'd1);
    chk("clear_rdata_zero", rsp_rdata_o, 512'd0);
    chk("clear_no_rsp", 512'(rsp_valid_o), 512'd0);
    count_busy(n, ready_seen);
    chk("clear_cycles", 512'(n), 512'd32);
    chk("clear_ready_low_init", 512'(ready_seen), 512'd0);
    rd(5'd3);
    chk("clear_rd3", rsp_rdata_o, 512'd0);
    chk("clear_rd3_valid", 512'(rsp_valid_o), 512'd1);
    rd(5'd4);
    chk("clear_rd4", rsp_rdata_o, 512'd0);

    // Reset in the middle of INIT restarts the sweep from 0
    wr(1'b0, 5'd9, {32{8'h99}}, '1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    count_busy(n, ready_seen);
    chk("rst_mid_init_cycles", 512'(n), 512'd32);
    rd(5'd9);
    chk("rst_mid_init_rd9", rsp_rdata_o, 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
